// File: rtl/scalar_writeback_arbiter.sv
// Writeback arbiter for the scalar register file write port: ALU path vs. buffered load returns,
// with a starvation guard. Optional load bypass of the empty FIFO under `SCALAR_WB_BYPASS_EN.
module scalar_writeback_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_wsel,
  input  logic [31:0]              alu_wdata,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_wsel,
  input  logic [31:0]              ld_wdata,
  output logic                     wen,
  output logic [4:0]               wsel,
  output logic [31:0]              wdata,
  output logic                     alu_stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    LIMIT_C = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_BYPASS
  } src_e;

  typedef struct packed {
    logic [4:0]  wsel;
    logic [31:0] wdata;
  } wb_t;

  wb_t           mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          ld_ready_q, ld_ready_d;
  logic          proto_err_q, proto_err_d;
  logic          wen_q, wen_d;
  logic [4:0]    wsel_q;
  logic [31:0]   wdata_q;

  src_e src;
  wb_t  head;
  wb_t  ld_word;
  wb_t  win;
  logic empty;
  logic ld_fire;
  logic push;
  logic pop;

  // NOTE: every signal assigned in this always_comb gets a default first, so no latch is inferred.
  always_comb begin
    empty   = (count_q == '0);
    ld_fire = ld_valid && ld_ready_q;
    head    = mem_q[rd_ptr_q];
    ld_word = '{wsel: ld_wsel, wdata: ld_wdata};

    // A stalled ALU request is never eligible; it only flags a protocol error.
    src = SRC_NONE;
    if (stall_q && !empty) begin
      src = SRC_FIFO;
    end else if (alu_valid && !stall_q) begin
      src = SRC_ALU;
    end else if (!empty) begin
      src = SRC_FIFO;
`ifdef SCALAR_WB_BYPASS_EN
    end else if (ld_fire && !alu_valid && !stall_q) begin
      src = SRC_BYPASS;
`endif
    end

    win = '0;
    case (src)
      SRC_ALU:    win = '{wsel: alu_wsel, wdata: alu_wdata};
      SRC_FIFO:   win = head;
      SRC_BYPASS: win = ld_word;
      default:    win = '0;
    endcase

    pop  = (src == SRC_FIFO);
    push = ld_fire && (src != SRC_BYPASS);

    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Ready is registered off the next occupancy, so a full FIFO refuses even while popping.
    ld_ready_d = (count_d < DEPTH_C);

    starve_d = starve_q;
    if (pop || empty || stall_q) begin
      starve_d = '0;
    end else if (src == SRC_ALU) begin
      starve_d = starve_q + 8'd1;
    end
    stall_d = (starve_d == LIMIT_C);

    proto_err_d = proto_err_q || (alu_valid && stall_q);

    // r0 writes still consume their source but never assert the write enable.
    wen_d = (src != SRC_NONE) && (win.wsel != 5'd0);
  end

  // NOTE: the FIFO storage is not reset; count and pointers alone define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ld_word;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      stall_q     <= 1'b0;
      ld_ready_q  <= 1'b0;
      proto_err_q <= 1'b0;
      wen_q       <= 1'b0;
      wsel_q      <= '0;
      wdata_q     <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      stall_q     <= stall_d;
      ld_ready_q  <= ld_ready_d;
      proto_err_q <= proto_err_d;
      wen_q       <= wen_d;
      if (src != SRC_NONE) begin
        wsel_q  <= win.wsel;
        wdata_q <= win.wdata;
      end
    end
  end

  assign ld_ready  = ld_ready_q;
  assign wen       = wen_q;
  assign wsel      = wsel_q;
  assign wdata     = wdata_q;
  assign alu_stall = stall_q;
  assign count     = count_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
// Directed bench for scalar_writeback_arbiter: vector table plus hand sequences for
// starvation, protocol error and the load bypass path.
module tb_scalar_writeback_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        alu_valid;
  logic [4:0]  alu_wsel;
  logic [31:0] alu_wdata;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_wsel;
  logic [31:0] ld_wdata;
  logic        wen;
  logic [4:0]  wsel;
  logic [31:0] wdata;
  logic        alu_stall;
  logic [2:0]  count;
  logic        proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  scalar_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .CLK(CLK), .RST(RST),
    .alu_valid(alu_valid), .alu_wsel(alu_wsel), .alu_wdata(alu_wdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wsel(ld_wsel), .ld_wdata(ld_wdata),
    .wen(wen), .wsel(wsel), .wdata(wdata),
    .alu_stall(alu_stall), .count(count), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aw;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lw;
    logic [31:0] ld;
    logic        e_wen;
    logic [4:0]  e_wsel;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic        e_ready;
    logic [2:0]  e_count;
    logic        e_perr;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_wsel = '0; alu_wdata = '0;
    ld_valid  = 1'b0; ld_wsel  = '0; ld_wdata  = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    tick();
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_ready", 32'(ld_ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    RST = 1'b0;
    tick();
    check("post_rst_ready", 32'(ld_ready), 32'd1);
  endtask

  initial begin
    int   n_acc;
    logic acc;

    RST = 1'b1;
    idle_inputs();

    //           rst   av    aw     ad            lv    lw     ld         wen   wsel   wdata          stall ready count perr
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 5'd9,  32'h1234,     1'b1, 5'd8,  32'h55,    1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 3'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 3'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,     1'b1, 5'd5,  32'hDEADBEEF,  1'b0, 1'b1, 3'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 3'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,    1'b1, 5'd3,  32'h11,        1'b0, 1'b1, 3'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b1, 5'd4,  32'h22,        1'b0, 1'b1, 3'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 3'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 5'd0,  32'h1,        1'b1, 5'd0,  32'h2,     1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 3'd1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 3'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 3'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 5'd9,  32'h99,       1'b1, 5'd10, 32'hAA,    1'b1, 5'd9,  32'h99,        1'b0, 1'b1, 3'd1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 3'd0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 3'd0, 1'b0};

    #2;
    for (int i = 0; i < 14; i++) begin
      RST = vecs[i].rst;
      alu_valid = vecs[i].av; alu_wsel = vecs[i].aw; alu_wdata = vecs[i].ad;
      ld_valid  = vecs[i].lv; ld_wsel  = vecs[i].lw; ld_wdata  = vecs[i].ld;
      tick();
      check($sformatf("vec%0d_wen", i), 32'(wen), 32'(vecs[i].e_wen));
      if (vecs[i].e_wen) begin
        check($sformatf("vec%0d_wsel", i), 32'(wsel), 32'(vecs[i].e_wsel));
        check($sformatf("vec%0d_wdata", i), wdata, vecs[i].e_wdata);
      end
      check($sformatf("vec%0d_stall", i), 32'(alu_stall), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d_ready", i), 32'(ld_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_perr", i), 32'(proto_err), 32'(vecs[i].e_perr));
    end

    // Starvation: five loads against a continuously busy ALU that honours alu_stall.
    do_reset();
    n_acc = 0;
    for (int c = 1; c <= 11; c++) begin
      alu_valid = !alu_stall; alu_wsel = 5'd20; alu_wdata = 32'h1000 + 32'(c);
      ld_valid  = (n_acc < 5); ld_wsel = 5'd10 + 5'(n_acc); ld_wdata = 32'hA0 + 32'(n_acc);
      acc = ld_valid && ld_ready;
      tick();
      if (acc) n_acc++;
      if (c <= 4) begin
        check($sformatf("stv%0d_count", c), 32'(count), 32'(c));
        check($sformatf("stv%0d_ready", c), 32'(ld_ready), (c < 4) ? 32'd1 : 32'd0);
        check($sformatf("stv%0d_wdata", c), wdata, 32'h1000 + 32'(c));
      end else if (c <= 8) begin
        check($sformatf("stv%0d_stall", c), 32'(alu_stall), 32'd0);
        check($sformatf("stv%0d_ready", c), 32'(ld_ready), 32'd0);
      end else if (c == 9) begin
        check("stv9_stall", 32'(alu_stall), 32'd1);
        check("stv9_wdata", wdata, 32'h1009);
        check("stv9_count", 32'(count), 32'd4);
      end else if (c == 10) begin
        check("stv10_wen", 32'(wen), 32'd1);
        check("stv10_wsel", 32'(wsel), 32'd10);
        check("stv10_wdata", wdata, 32'hA0);
        check("stv10_stall", 32'(alu_stall), 32'd0);
        check("stv10_ready", 32'(ld_ready), 32'd1);
        check("stv10_count", 32'(count), 32'd3);
      end else begin
        check("stv11_count", 32'(count), 32'd4);
        check("stv11_ready", 32'(ld_ready), 32'd0);
        check("stv11_accepted", 32'(n_acc), 32'd5);
        check("stv11_wdata", wdata, 32'h100B);
      end
    end
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("drain%0d_wen", k), 32'(wen), 32'd1);
      check($sformatf("drain%0d_wsel", k), 32'(wsel), 32'(10 + k));
      check($sformatf("drain%0d_wdata", k), wdata, 32'hA0 + 32'(k));
      check($sformatf("drain%0d_count", k), 32'(count), 32'(4 - k));
    end

    // Protocol error: ALU keeps requesting straight through the stall cycle.
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      alu_valid = 1'b1; alu_wsel = 5'd20; alu_wdata = 32'h2000 + 32'(c);
      ld_valid = (c == 1); ld_wsel = 5'd12; ld_wdata = 32'h5A;
      tick();
    end
    check("perr_stall", 32'(alu_stall), 32'd1);
    check("perr_before", 32'(proto_err), 32'd0);
    alu_valid = 1'b1; alu_wsel = 5'd21; alu_wdata = 32'hBAD; ld_valid = 1'b0;
    tick();
    check("perr_pop_wsel", 32'(wsel), 32'd12);
    check("perr_pop_wdata", wdata, 32'h5A);
    check("perr_set", 32'(proto_err), 32'd1);
    check("perr_count", 32'(count), 32'd0);
    alu_wsel = 5'd22; alu_wdata = 32'hC0;
    tick();
    check("perr_next_wsel", 32'(wsel), 32'd22);
    check("perr_next_wdata", wdata, 32'hC0);
    check("perr_sticky1", 32'(proto_err), 32'd1);
    idle_inputs();
    tick();
    check("perr_idle_wen", 32'(wen), 32'd0);
    check("perr_sticky2", 32'(proto_err), 32'd1);
    RST = 1'b1;
    tick();
    check("perr_cleared", 32'(proto_err), 32'd0);
    RST = 1'b0;
    tick();

    // Lone load into an idle unit: bypassed or buffered depending on the build.
    do_reset();
    ld_valid = 1'b1; ld_wsel = 5'd7; ld_wdata = 32'h77;
    tick();
    idle_inputs();
`ifdef SCALAR_WB_BYPASS_EN
    check("byp_wen", 32'(wen), 32'd1);
    check("byp_wsel", 32'(wsel), 32'd7);
    check("byp_wdata", wdata, 32'h77);
    check("byp_count", 32'(count), 32'd0);
    tick();
    check("byp_after_wen", 32'(wen), 32'd0);
`else
    check("nobyp_wen1", 32'(wen), 32'd0);
    check("nobyp_count1", 32'(count), 32'd1);
    tick();
    check("nobyp_wen2", 32'(wen), 32'd1);
    check("nobyp_wsel2", 32'(wsel), 32'd7);
    check("nobyp_wdata2", wdata, 32'h77);
    check("nobyp_count2", 32'(count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
